// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command controller.
//   SYNC_BYTE / ACK_BYTE / NAK_BYTE : framing and reply byte values
//   rx_state_t                      : packet framing FSM states
//   ack_state_t                     : reply transmitter sequencing states
//   calc_chk()                      : packet checksum (CMD xor DATA)
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    GET_CMD,
    GET_DATA,
    GET_CHK
  } rx_state_t;

  typedef enum logic {
    A_IDLE,
    A_WAIT
  } ack_state_t;

  function automatic logic [7:0] calc_chk(input logic [7:0] cmd, input logic [7:0] data);
    return cmd ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_ack.sv
// Reply sequencer: a single-entry pending slot feeding the UART transmitter.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   queue_valid   : one-cycle request to send queue_code (overwrites any pending code)
//   queue_code    : ACK/NAK byte to queue
//   tx_done_tick  : transmitter finished the byte in flight
//   tx_start      : one-cycle strobe to start transmitting tx_din
//   tx_din        : byte being transmitted, stable until tx_done_tick
//   ack_busy      : a byte is in flight (FSM not idle)
module uart_cmd_ack
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       queue_valid,
  input  logic [7:0] queue_code,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] tx_din,
  output logic       ack_busy
);

  ack_state_t state_q, state_d;
  logic       pending_q, pending_d;
  logic [7:0] pend_code_q, pend_code_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_din_q, tx_din_d;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    pend_code_d = pend_code_q;
    tx_start_d  = 1'b0;
    tx_din_d    = tx_din_q;

    case (state_q)
      A_IDLE: begin
        if (pending_q) begin
          tx_start_d = 1'b1;
          tx_din_d   = pend_code_q;
          pending_d  = 1'b0;
          state_d    = A_WAIT;
        end
      end
      A_WAIT: begin
        if (tx_done_tick) begin
          state_d = A_IDLE;
        end
      end
      default: state_d = A_IDLE;
    endcase

    // Applied after the consume above so that a code queued in the same
    // cycle the slot is drained stays pending (most recent wins).
    if (queue_valid) begin
      pending_d   = 1'b1;
      pend_code_d = queue_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= A_IDLE;
      pending_q   <= 1'b0;
      pend_code_q <= 8'h00;
      tx_start_q  <= 1'b0;
      tx_din_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pend_code_q <= pend_code_d;
      tx_start_q  <= tx_start_d;
      tx_din_q    <= tx_din_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
  assign ack_busy = (state_q != A_IDLE);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Packet-level controller between the UART receiver and the game logic.
// Frames SYNC/CMD/DATA/CHK packets, checks CHK = CMD ^ DATA, aborts a packet
// when the gap between its bytes reaches TIMEOUT_CYCLES, strobes valid
// commands out and answers every completed packet with ACK or NAK.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   rx_done_tick, dout : received byte strobe and value
//   tx_done_tick       : transmitter finished current byte
//   tx_start, tx_din   : transmit request strobe and byte
//   cmd_valid          : one-cycle strobe, new command on cmd_code/cmd_data
//   cmd_code, cmd_data : last valid command, held until the next one
//   err_cnt            : saturating count of checksum errors plus timeouts
//   busy               : packet in progress or reply in flight
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ERR_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_done_tick,
  input  logic [7:0]       dout,
  input  logic             tx_done_tick,
  output logic             tx_start,
  output logic [7:0]       tx_din,
  output logic             cmd_valid,
  output logic [7:0]       cmd_code,
  output logic [7:0]       cmd_data,
  output logic [ERR_W-1:0] err_cnt,
  output logic             busy
);

  localparam int                TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX = {ERR_W{1'b1}};

  rx_state_t        rx_state_q, rx_state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       cmd_code_q, cmd_code_d;
  logic [7:0]       cmd_data_q, cmd_data_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic             timeout;
  logic             err_inc;
  logic             queue_valid;
  logic [7:0]       queue_code;
  logic             ack_busy;

  always_comb begin
    rx_state_d  = rx_state_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    cmd_code_d  = cmd_code_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = 1'b0;
    err_inc     = 1'b0;
    queue_valid = 1'b0;
    queue_code  = ACK_BYTE;

    // A byte arriving on the expiry cycle takes priority over the abort.
    timeout = (rx_state_q != WAIT_SYNC) && !rx_done_tick && (to_cnt_q == TO_LAST);

    if (rx_done_tick || (rx_state_q == WAIT_SYNC) || timeout) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (timeout) begin
      rx_state_d = WAIT_SYNC;
      err_inc    = 1'b1;
    end else if (rx_done_tick) begin
      case (rx_state_q)
        WAIT_SYNC: begin
          if (dout == SYNC_BYTE) begin
            rx_state_d = GET_CMD;
          end
        end
        GET_CMD: begin
          cmd_d      = dout;
          rx_state_d = GET_DATA;
        end
        GET_DATA: begin
          data_d     = dout;
          rx_state_d = GET_CHK;
        end
        GET_CHK: begin
          rx_state_d  = WAIT_SYNC;
          queue_valid = 1'b1;
          if (dout == calc_chk(cmd_q, data_q)) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = cmd_q;
            cmd_data_d  = data_q;
            queue_code  = ACK_BYTE;
          end else begin
            err_inc    = 1'b1;
            queue_code = NAK_BYTE;
          end
        end
        default: rx_state_d = WAIT_SYNC;
      endcase
    end

    if (err_inc && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= WAIT_SYNC;
      cmd_q       <= 8'h00;
      data_q      <= 8'h00;
      cmd_code_q  <= 8'h00;
      cmd_data_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      err_cnt_q   <= '0;
      to_cnt_q    <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      cmd_code_q  <= cmd_code_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      err_cnt_q   <= err_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  uart_cmd_ack u_ack (
    .clk          (clk),
    .rst_n        (rst_n),
    .queue_valid  (queue_valid),
    .queue_code   (queue_code),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .ack_busy     (ack_busy)
  );

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_data  = cmd_data_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (rx_state_q != WAIT_SYNC) || ack_busy;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed packets plus randomized traffic, checked
// against a packet-level reference model (byte list per packet, cycle of the
// last byte, error count), and a transmitter responder that completes each
// reply a few cycles after tx_start unless held off.
module tb_uart_cmd_ctrl;

  localparam int T       = 50;
  localparam int EW      = 8;
  localparam int ERR_TOP = (1 << EW) - 1;

  typedef struct {
    logic [7:0]  code;
    logic [7:0]  data;
    int unsigned cyc;
  } cv_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rx_done_tick = 1'b0;
  logic [7:0]    dout = 8'h00;
  logic          tx_done_tick = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_din;
  logic          cmd_valid;
  logic [7:0]    cmd_code;
  logic [7:0]    cmd_data;
  logic [EW-1:0] err_cnt;
  logic          busy;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(T), .ERR_W(EW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_data     (cmd_data),
    .err_cnt      (err_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  pkt[$];
  int unsigned last_tick = 0;
  int          m_err = 0;
  logic [7:0]  m_code = 8'h00;
  logic [7:0]  m_data = 8'h00;
  bit          tx_model_en = 1'b1;
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  cv_t         exp_cv[$];
  cv_t         cv_log[$];

  // A partial packet is abandoned once more than T cycles separate its last
  // byte from the present cycle; the abort shows from cycle last_tick+T+1.
  function automatic void model_sync(input int unsigned now);
    if (pkt.size() != 0 && now > last_tick + T) begin
      pkt.delete();
      if (m_err < ERR_TOP) m_err++;
      $display("cycle %0d: partial packet dropped on inter-byte timeout", now);
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int unsigned now);
    model_sync(now);
    last_tick = now;
    if (pkt.size() == 0) begin
      if (b == 8'hA5) pkt.push_back(b);
      return;
    end
    pkt.push_back(b);
    if (pkt.size() == 4) begin
      if ((pkt[1] ^ pkt[2]) == pkt[3]) begin
        m_code = pkt[1];
        m_data = pkt[2];
        exp_cv.push_back('{pkt[1], pkt[2], now + 1});
        if (tx_model_en) exp_tx.push_back(8'h06);
        $display("cycle %0d: packet cmd=%02h data=%02h chk=%02h -> ACK", now, pkt[1], pkt[2], pkt[3]);
      end else begin
        if (m_err < ERR_TOP) m_err++;
        if (tx_model_en) exp_tx.push_back(8'h15);
        $display("cycle %0d: packet cmd=%02h data=%02h chk=%02h -> NAK", now, pkt[1], pkt[2], pkt[3]);
      end
      pkt.delete();
    end
  endfunction

  // ---------------- monitor ----------------
  logic       in_flight = 1'b0;
  logic [7:0] held_din = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight <= 1'b0;
    end else begin
      if (tx_start) begin
        chk("tx_start_while_in_flight", {31'd0, in_flight}, 32'd0);
        tx_log.push_back(tx_din);
        held_din  <= tx_din;
        in_flight <= 1'b1;
      end else if (in_flight) begin
        chk("tx_din_hold", {24'd0, tx_din}, {24'd0, held_din});
        if (tx_done_tick) in_flight <= 1'b0;
      end
      if (cmd_valid) cv_log.push_back('{cmd_code, cmd_data, cyc});
    end
  end

  // ---------------- transmitter responder ----------------
  bit tx_auto = 1'b1;

  initial begin : tx_responder
    forever begin
      @(negedge clk);
      if (tx_start) begin
        wait (tx_auto);
        repeat (2) @(posedge clk);
        #1 tx_done_tick = 1'b1;
        @(posedge clk);
        #1 tx_done_tick = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) step();
    rx_done_tick = 1'b1;
    dout         = b;
    model_byte(b, cyc);
    step();
    rx_done_tick = 1'b0;
  endtask

  task automatic settle();
    repeat (T + 10) step();
    model_sync(cyc);
  endtask

  task automatic check_state(input string tag);
    model_sync(cyc);
    chk({tag, "_err_cnt"},  {24'd0, err_cnt},  m_err);
    chk({tag, "_cmd_code"}, {24'd0, cmd_code}, {24'd0, m_code});
    chk({tag, "_cmd_data"}, {24'd0, cmd_data}, {24'd0, m_data});
  endtask

  task automatic check_logs(input string tag);
    cv_t a, e;
    chk({tag, "_tx_count"}, tx_log.size(), exp_tx.size());
    while (tx_log.size() != 0 && exp_tx.size() != 0)
      chk({tag, "_tx_din"}, {24'd0, tx_log.pop_front()}, {24'd0, exp_tx.pop_front()});
    chk({tag, "_cmd_valid_count"}, cv_log.size(), exp_cv.size());
    while (cv_log.size() != 0 && exp_cv.size() != 0) begin
      a = cv_log.pop_front();
      e = exp_cv.pop_front();
      chk({tag, "_cv_code"},  {24'd0, a.code}, {24'd0, e.code});
      chk({tag, "_cv_data"},  {24'd0, a.data}, {24'd0, e.data});
      chk({tag, "_cv_cycle"}, a.cyc, e.cyc);
    end
    tx_log.delete(); exp_tx.delete(); cv_log.delete(); exp_cv.delete();
  endtask

  function automatic int rgap();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return T - 1;
    if (r == 1) return T;
    if (r == 2) return T + 3;
    return $urandom_range(2, 6);
  endfunction

  // ---------------- directed + random sequence ----------------
  int unsigned c1;
  int          err_before;
  logic [7:0]  rc, rd, rk;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tx_start",  {31'd0, tx_start},  32'd0);
    chk("rst_tx_din",    {24'd0, tx_din},    32'd0);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_cmd_code",  {24'd0, cmd_code},  32'd0);
    chk("rst_cmd_data",  {24'd0, cmd_data},  32'd0);
    chk("rst_err_cnt",   {24'd0, err_cnt},   32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Valid packet.
    send_byte(8'hA5, 2); send_byte(8'h10, 2); send_byte(8'h3C, 2); send_byte(8'h2C, 2);
    repeat (10) step();
    chk("p1_cmd_code", {24'd0, cmd_code}, 32'h10);
    chk("p1_cmd_data", {24'd0, cmd_data}, 32'h3C);
    chk("p1_err_cnt",  {24'd0, err_cnt},  32'd0);
    check_state("p1");
    check_logs("p1");

    // Bad checksum: NAK, command outputs keep the previous values.
    send_byte(8'hA5, 2); send_byte(8'h10, 2); send_byte(8'h3C, 2); send_byte(8'h00, 2);
    repeat (10) step();
    chk("p2_err_cnt",  {24'd0, err_cnt},  32'd1);
    chk("p2_cmd_code", {24'd0, cmd_code}, 32'h10);
    check_state("p2");
    check_logs("p2");

    // Preamble garbage, then 0xA5 as payload.
    send_byte(8'h00, 2); send_byte(8'hFF, 2); send_byte(8'hA5, 2);
    send_byte(8'hA5, 2); send_byte(8'h01, 2); send_byte(8'hA4, 2);
    repeat (10) step();
    chk("p3_cmd_code", {24'd0, cmd_code}, 32'hA5);
    chk("p3_cmd_data", {24'd0, cmd_data}, 32'h01);
    check_state("p3");
    check_logs("p3");

    // Timeout: abort shows exactly one cycle after the expiry cycle.
    settle();
    err_before = m_err;
    send_byte(8'hA5, 2); send_byte(8'h10, 2);
    c1 = last_tick;
    while (cyc < c1 + T) step();
    model_sync(cyc);
    chk("to_busy_at_expiry", {31'd0, busy}, {31'd0, pkt.size() != 0});
    chk("to_err_at_expiry",  {24'd0, err_cnt}, m_err);
    step();
    model_sync(cyc);
    chk("to_busy_after_expiry", {31'd0, busy}, {31'd0, pkt.size() != 0});
    chk("to_err_after_expiry",  {24'd0, err_cnt}, err_before + 1);
    repeat (10) step();
    check_logs("to_no_reply");
    send_byte(8'hA5, 2); send_byte(8'h20, 2); send_byte(8'h01, 2); send_byte(8'h21, 2);
    repeat (10) step();
    chk("to_recover_code", {24'd0, cmd_code}, 32'h20);
    check_state("to_recover");
    check_logs("to_recover");

    // Byte landing on the expiry cycle is accepted.
    send_byte(8'hA5, 2); send_byte(8'h33, 2); send_byte(8'h0F, T - 1); send_byte(8'h3C, 2);
    repeat (10) step();
    chk("edge_accept_code", {24'd0, cmd_code}, 32'h33);
    check_state("edge_accept");
    check_logs("edge_accept");

    // One cycle later it is too late.
    err_before = m_err;
    send_byte(8'hA5, 2); send_byte(8'h44, 2); send_byte(8'h0F, T); send_byte(8'h4B, 2);
    repeat (10) step();
    chk("edge_late_err", {24'd0, err_cnt}, err_before + 1);
    check_state("edge_late");
    check_logs("edge_late");

    // Randomized traffic.
    for (int p = 0; p < 40; p++) begin
      rc = 8'($urandom);
      rd = 8'($urandom);
      rk = rc ^ rd;
      if ($urandom_range(0, 2) == 0) rk = rk ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 255)), rgap());
      send_byte(8'hA5, rgap()); send_byte(rc, rgap()); send_byte(rd, rgap()); send_byte(rk, rgap());
      repeat (8) step();
      check_state("rnd");
      chk("rnd_busy", {31'd0, busy}, {31'd0, pkt.size() != 0});
    end
    settle();
    check_state("rnd_end");
    check_logs("rnd");

    // Reply held: second ACK in the slot is overwritten by the NAK.
    tx_auto = 1'b0;
    tx_model_en = 1'b0;
    send_byte(8'hA5, 2); send_byte(8'h11, 2); send_byte(8'h22, 2); send_byte(8'h33, 2);
    send_byte(8'hA5, 2); send_byte(8'h44, 2); send_byte(8'h55, 2); send_byte(8'h11, 2);
    send_byte(8'hA5, 2); send_byte(8'h66, 2); send_byte(8'h77, 2); send_byte(8'h00, 2);
    repeat (10) step();
    chk("hold_tx_count", tx_log.size(), 32'd1);
    chk("hold_busy",     {31'd0, busy}, 32'd1);
    tx_auto = 1'b1;
    repeat (20) step();
    exp_tx.push_back(8'h06);
    exp_tx.push_back(8'h15);
    check_state("hold");
    check_logs("hold");
    tx_model_en = 1'b1;

    // Reset in the middle of a packet.
    settle();
    check_logs("pre_reset");
    send_byte(8'hA5, 2); send_byte(8'h10, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_start",  {31'd0, tx_start},  32'd0);
    chk("mid_rst_tx_din",    {24'd0, tx_din},    32'd0);
    chk("mid_rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("mid_rst_cmd_code",  {24'd0, cmd_code},  32'd0);
    chk("mid_rst_cmd_data",  {24'd0, cmd_data},  32'd0);
    chk("mid_rst_err_cnt",   {24'd0, err_cnt},   32'd0);
    chk("mid_rst_busy",      {31'd0, busy},      32'd0);
    pkt.delete(); m_err = 0; m_code = 8'h00; m_data = 8'h00;
    tx_log.delete(); exp_tx.delete(); cv_log.delete(); exp_cv.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    send_byte(8'h3C, 2); send_byte(8'h2C, 2);
    repeat (10) step();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    check_state("post_rst");
    check_logs("post_rst");

    // Error counter saturation.
    tx_model_en = 1'b0;
    for (int p = 0; p < 300; p++) begin
      rc = 8'($urandom);
      send_byte(8'hA5, 0); send_byte(rc, 0); send_byte(8'h5A, 0); send_byte(rc ^ 8'h5B, 0);
    end
    settle();
    tx_log.delete();
    chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
    check_state("sat");
    check_logs("sat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
